// File: rtl/ex_mem_reg_pkg.sv
// ============================================================================
// Module  : ex_mem_reg_pkg
// Brief   : Shared widths, op codes and the MEM payload type for the EX->MEM stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ex_mem_reg_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int DREG_W     = 64;

  localparam logic [REG_W-1:0]      c_zero_word    = '0;
  localparam logic [REG_ADDR_W-1:0] c_nop_reg_addr = '0;
  localparam logic                  c_write_en     = 1'b1;
  localparam logic                  c_write_dis    = 1'b0;

  localparam logic [ALUOP_W-1:0] c_exe_nop_op = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] c_exe_lb_op  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] c_exe_lbu_op = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] c_exe_lh_op  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] c_exe_lhu_op = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] c_exe_lw_op  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] c_exe_lwl_op = 8'b1110_0010;
  localparam logic [ALUOP_W-1:0] c_exe_lwr_op = 8'b1110_0110;
  localparam logic [ALUOP_W-1:0] c_exe_ll_op  = 8'b1111_0000;
  localparam logic [ALUOP_W-1:0] c_exe_sb_op  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] c_exe_sh_op  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] c_exe_sw_op  = 8'b1110_1011;
  localparam logic [ALUOP_W-1:0] c_exe_swl_op = 8'b1110_1010;
  localparam logic [ALUOP_W-1:0] c_exe_swr_op = 8'b1110_1110;
  localparam logic [ALUOP_W-1:0] c_exe_sc_op  = 8'b1111_1000;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [REG_W-1:0]      wdata;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic                  whilo;
    logic [REG_W-1:0]      hi;
    logic [REG_W-1:0]      lo;
    logic [ALUOP_W-1:0]    aluop;
    logic [REG_W-1:0]      mem_addr;
    logic [REG_W-1:0]      reg2;
  } mem_bus_t;

  localparam mem_bus_t c_mem_bubble = '{
    wdata:    c_zero_word,
    wd:       c_nop_reg_addr,
    wreg:     c_write_dis,
    whilo:    c_write_dis,
    hi:       c_zero_word,
    lo:       c_zero_word,
    aluop:    c_exe_nop_op,
    mem_addr: c_zero_word,
    reg2:     c_zero_word
  };

  // Unaligned-merge ops (lwl/lwr/swl/swr) and byte ops report ACC_NONE: they can never fault.
  function automatic acc_size_e acc_size(input logic [ALUOP_W-1:0] op);
    acc_size_e r;
    case (op)
      c_exe_lh_op, c_exe_lhu_op, c_exe_sh_op:              r = ACC_HALF;
      c_exe_lw_op, c_exe_sw_op, c_exe_ll_op, c_exe_sc_op:  r = ACC_WORD;
      default:                                             r = ACC_NONE;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_reg_align_chk.sv
// ============================================================================
// Module  : ex_mem_align_chk
// Brief   : Combinational misaligned half/word access detector.
//           Exists only when EX_MEM_ALIGN_CHK_EN is defined.
// Rev     : 1.0
// ============================================================================
`default_nettype none

`ifdef EX_MEM_ALIGN_CHK_EN
module ex_mem_align_chk
  import ex_mem_reg_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_aluop,
  input  logic [1:0]         i_addr,
  output logic               o_misalign
);

  always_comb begin
    o_misalign = 1'b0;
    case (acc_size(i_aluop))
      ACC_HALF: o_misalign = i_addr[0];
      ACC_WORD: o_misalign = |i_addr;
      default:  o_misalign = 1'b0;
    endcase
  end

endmodule
`endif

`default_nettype wire

// File: rtl/ex_mem_reg.sv
// ============================================================================
// Module  : ex_mem_reg
// Brief   : EX->MEM pipeline register with bubble/flush/hold and madd/msub state
//           carry. Optional alignment check enabled by EX_MEM_ALIGN_CHK_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic [REG_W-1:0]      ex_wdata,
  input  logic [REG_ADDR_W-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic                  ex_whilo,
  input  logic [REG_W-1:0]      ex_hi,
  input  logic [REG_W-1:0]      ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [REG_W-1:0]      ex_mem_addr,
  input  logic [REG_W-1:0]      ex_reg2,
  input  logic [DREG_W-1:0]     hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [REG_W-1:0]      mem_wdata,
  output logic [REG_ADDR_W-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic                  mem_whilo,
  output logic [REG_W-1:0]      mem_hi,
  output logic [REG_W-1:0]      mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [REG_W-1:0]      mem_mem_addr,
  output logic [REG_W-1:0]      mem_reg2,
  output logic [DREG_W-1:0]     hilo_o,
  output logic [1:0]            cnt_o,
  output logic                  mem_misalign_o
);

  mem_bus_t          w_ex;
  mem_bus_t          w_cap;
  mem_bus_t          r_mem;
  logic [DREG_W-1:0] r_hilo;
  logic [1:0]        r_cnt;
  logic              w_bubble;
  logic              w_load;
  logic              w_unused;

  // EX stalled while MEM runs: MEM gets a NOP but EX's multi-cycle state is kept.
  assign w_bubble = stall[3] & ~stall[4];
  assign w_load   = ~stall[3];
  assign w_unused = ^{stall[5], stall[2:0]};

  assign w_ex = '{
    wdata:    ex_wdata,
    wd:       ex_wd,
    wreg:     ex_wreg,
    whilo:    ex_whilo,
    hi:       ex_hi,
    lo:       ex_lo,
    aluop:    ex_aluop,
    mem_addr: ex_mem_addr,
    reg2:     ex_reg2
  };

`ifdef EX_MEM_ALIGN_CHK_EN
  logic w_misalign;
  logic r_misalign;

  ex_mem_align_chk u_align_chk (
    .i_aluop    (ex_aluop),
    .i_addr     (ex_mem_addr[1:0]),
    .o_misalign (w_misalign)
  );

  // A faulting access reaches MEM as a non-writing NOP so no memory side effect occurs.
  always_comb begin
    w_cap = w_ex;
    if (w_misalign) begin
      w_cap.wreg  = c_write_dis;
      w_cap.aluop = c_exe_nop_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else if (flush || w_bubble) begin
      r_misalign <= 1'b0;
    end else if (w_load) begin
      r_misalign <= w_misalign;
    end
  end

  assign mem_misalign_o = r_misalign;
`else
  assign w_cap          = w_ex;
  assign mem_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem  <= c_mem_bubble;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_mem  <= c_mem_bubble;
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (w_bubble) begin
      r_mem  <= c_mem_bubble;
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end else if (w_load) begin
      r_mem  <= w_cap;
      r_hilo <= '0;
      r_cnt  <= '0;
    end
  end

  assign mem_wdata    = r_mem.wdata;
  assign mem_wd       = r_mem.wd;
  assign mem_wreg     = r_mem.wreg;
  assign mem_whilo    = r_mem.whilo;
  assign mem_hi       = r_mem.hi;
  assign mem_lo       = r_mem.lo;
  assign mem_aluop    = r_mem.aluop;
  assign mem_mem_addr = r_mem.mem_addr;
  assign mem_reg2     = r_mem.reg2;
  assign hilo_o       = r_hilo;
  assign cnt_o        = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_reg.sv
// ============================================================================
// Module  : tb_ex_mem_reg
// Brief   : Directed + randomized self-checking bench for ex_mem_reg.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_misalign_o;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int checks = 0;
  int errors = 0;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o), .mem_misalign_o(mem_misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata, hi, lo, addr, reg2;
    logic [4:0]  wd;
    logic        wreg, whilo, mis;
    logic [7:0]  aluop;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } exp_t;

  exp_t e;

  logic [7:0] op_pool [14] = '{
    8'b1110_0000, 8'b1110_0100, 8'b1110_0001, 8'b1110_0101, 8'b1110_0011,
    8'b1110_0010, 8'b1110_0110, 8'b1111_0000, 8'b1110_1000, 8'b1110_1001,
    8'b1110_1011, 8'b1110_1010, 8'b1110_1110, 8'b1111_1000
  };

  function automatic exp_t zero_exp();
    exp_t z;
    z.wdata = '0; z.hi = '0; z.lo = '0; z.addr = '0; z.reg2 = '0; z.wd = '0;
    z.wreg = 1'b0; z.whilo = 1'b0; z.mis = 1'b0; z.aluop = '0; z.hilo = '0; z.cnt = '0;
    return z;
  endfunction

  function automatic logic misaligned(input logic [7:0] op, input logic [31:0] a);
    logic half, word, m;
    half = (op == 8'b1110_0001) || (op == 8'b1110_0101) || (op == 8'b1110_1001);
    word = (op == 8'b1110_0011) || (op == 8'b1110_1011) ||
           (op == 8'b1111_0000) || (op == 8'b1111_1000);
    m = (half && a[0]) || (word && (a[1:0] != 2'b00));
`ifndef EX_MEM_ALIGN_CHK_EN
    m = 1'b0;
`endif
    return m;
  endfunction

  function automatic exp_t predict(input exp_t p);
    exp_t n;
    logic m;
    n = p;
    if (flush) begin
      n = zero_exp();
    end else if (stall[3] && !stall[4]) begin
      n = zero_exp();
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
    end else if (!stall[3]) begin
      m = misaligned(ex_aluop, ex_mem_addr);
      n.wdata = ex_wdata; n.wd = ex_wd; n.whilo = ex_whilo;
      n.hi = ex_hi; n.lo = ex_lo; n.addr = ex_mem_addr; n.reg2 = ex_reg2;
      n.wreg  = ex_wreg && !m;
      n.aluop = m ? 8'h00 : ex_aluop;
      n.mis   = m;
      n.hilo  = '0;
      n.cnt   = '0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".wdata"}, 64'(mem_wdata), 64'(e.wdata));
    chk({ph, ".wd"},    64'(mem_wd),    64'(e.wd));
    chk({ph, ".wreg"},  64'(mem_wreg),  64'(e.wreg));
    chk({ph, ".whilo"}, 64'(mem_whilo), 64'(e.whilo));
    chk({ph, ".hi"},    64'(mem_hi),    64'(e.hi));
    chk({ph, ".lo"},    64'(mem_lo),    64'(e.lo));
    chk({ph, ".aluop"}, 64'(mem_aluop), 64'(e.aluop));
    chk({ph, ".addr"},  64'(mem_mem_addr), 64'(e.addr));
    chk({ph, ".reg2"},  64'(mem_reg2),  64'(e.reg2));
    chk({ph, ".hilo"},  hilo_o,         e.hilo);
    chk({ph, ".cnt"},   64'(cnt_o),     64'(e.cnt));
    chk({ph, ".mis"},   64'(mem_misalign_o), 64'(e.mis));
  endtask

  task automatic cycle(input string ph);
    e = predict(e);
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)       stall = 6'b000000;
    else if (r < 6)  stall = 6'b001111;
    else if (r < 8)  stall = 6'b011111;
    else if (r == 8) stall = 6'b010000;
    else             stall = 6'($urandom);
    flush       = ($urandom_range(0, 7) == 0);
    ex_wdata    = $urandom; ex_hi = $urandom; ex_lo = $urandom; ex_reg2 = $urandom;
    ex_wd       = 5'($urandom); ex_wreg = 1'($urandom); ex_whilo = 1'($urandom);
    ex_mem_addr = $urandom;
    if ($urandom_range(0, 1) == 0) ex_mem_addr[1:0] = 2'b00;
    ex_aluop    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : op_pool[$urandom_range(0, 13)];
    hilo_i      = {$urandom, $urandom};
    cnt_i       = 2'($urandom);
  endtask

  task automatic set_mem(input logic [7:0] op, input logic [31:0] a, input logic [4:0] wd, input logic wr);
    stall = 6'b000000; flush = 1'b0;
    ex_aluop = op; ex_mem_addr = a; ex_wd = wd; ex_wreg = wr;
  endtask

  initial begin
    rst_n = 1'b1;
    rand_inputs();
    e = zero_exp();
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LW capture, one cycle latency
    rand_inputs();
    set_mem(8'b1110_0011, 32'h100, 5'd5, 1'b1);
    cycle("lw");
    chk("lw.aluop_direct", 64'(mem_aluop), 64'h0e3);
    chk("lw.addr_direct", 64'(mem_mem_addr), 64'h100);
    chk("lw.wd_direct", 64'(mem_wd), 64'd5);

    // madd first cycle: bubble to MEM, state looped back
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
    cycle("madd1");
    chk("madd1.hilo_direct", hilo_o, 64'h1_0000_0002);
    chk("madd1.cnt_direct", 64'(cnt_o), 64'd1);
    rand_inputs();
    stall = 6'b000000; flush = 1'b0;
    cycle("madd2");
    chk("madd2.cnt_direct", 64'(cnt_o), 64'd0);

    // valid SW held for three cycles of full stall
    rand_inputs();
    set_mem(8'b1110_1011, 32'h200, 5'd7, 1'b0);
    cycle("sw");
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall = 6'b011111; flush = 1'b0;
      cycle("hold");
    end
    chk("hold.addr_direct", 64'(mem_mem_addr), 64'h200);

    // flush beats an EX stall
    stall = 6'b001111; flush = 1'b0; hilo_i = 64'hdead_beef_0123_4567; cnt_i = 2'd1;
    cycle("pre_flush");
    flush = 1'b1;
    cycle("flush");
    chk("flush.hilo_direct", hilo_o, 64'd0);

    // alignment cases
    rand_inputs();
    set_mem(8'b1110_1011, 32'h102, 5'd3, 1'b0);
    cycle("sw_mis");
`ifdef EX_MEM_ALIGN_CHK_EN
    chk("sw_mis.flag_direct", 64'(mem_misalign_o), 64'd1);
    chk("sw_mis.aluop_direct", 64'(mem_aluop), 64'd0);
`else
    chk("sw_mis.flag_direct", 64'(mem_misalign_o), 64'd0);
    chk("sw_mis.aluop_direct", 64'(mem_aluop), 64'h0eb);
`endif
    rand_inputs();
    set_mem(8'b1110_0010, 32'h103, 5'd4, 1'b1);
    cycle("lwl");
    chk("lwl.flag_direct", 64'(mem_misalign_o), 64'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle("rand");
    end

    // asynchronous reset in the middle of traffic
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    e = zero_exp();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rand_inputs();
      cycle("rand2");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
